// File: rtl/mult_pkg.sv
// mult_pkg -- shared definitions for the multiplier issue block.
//   mult_issue_state_t : issue FSM state encoding
//   MULT_W             : default operand width
//   MULT_ISSUE_DEPTH   : default operand FIFO depth
package mult_pkg;

  localparam int MULT_W           = 32'd8;
  localparam int MULT_ISSUE_DEPTH = 32'd4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_DONE = 2'd2,
    HOLD      = 2'd3
  } mult_issue_state_t;

endpackage

// File: rtl/op_fifo.sv
// op_fifo -- synchronous operand FIFO, DEPTH entries of DW bits.
//   clk, rst (async active-low)
//   push/din   : write request and data (ignored when full)
//   pop/dout   : read request and head-of-queue data (ignored when empty)
//   full/empty : occupancy flags
//   count      : number of stored entries
// A push while full is refused even if a pop happens in the same cycle.
module op_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [DW-1:0]          din,
  output logic [DW-1:0]          dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DW-1:0] mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic          push_ok_s;
  logic          pop_ok_s;

  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;
  assign full      = (count_r == FULL_CNT);
  assign empty     = (count_r == {(AW+1){1'b0}});
  assign count     = count_r;
  assign dout      = mem_r[rd_ptr_r];

  // Storage array; contents are only read once written, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers wrap naturally (DEPTH is a power of two); count tracks push-pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + (AW+1)'(1'b1);
        2'b01:   count_r <= count_r - (AW+1)'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/mult_issue.sv
// mult_issue -- queues operand pairs and issues them one at a time to an
// external multiplier, holding each product until downstream accepts it.
//   clk, rst (async active-low)
//   op_valid/op_ready/op_a/op_b      : operand pair input handshake
//   mult_start/mult_a/mult_b         : request and operands to multiplier
//   mult_busy/mult_y                 : multiplier status and product
//   res_valid/res_ready/res_y        : result output handshake
//   fifo_cnt                         : operand FIFO occupancy
// Optional feature (macro MULT_ISSUE_ACC_EN): acc_clr input and acc_y output,
// a 4*W-bit running sum of every captured product.
module mult_issue
  import mult_pkg::*;
#(
  parameter int DEPTH = MULT_ISSUE_DEPTH,
  parameter int W     = MULT_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   op_valid,
  output logic                   op_ready,
  input  logic [W-1:0]           op_a,
  input  logic [W-1:0]           op_b,
  output logic                   mult_start,
  output logic [W-1:0]           mult_a,
  output logic [W-1:0]           mult_b,
  input  logic                   mult_busy,
  input  logic [2*W-1:0]         mult_y,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [2*W-1:0]         res_y,
  output logic [$clog2(DEPTH):0] fifo_cnt
`ifdef MULT_ISSUE_ACC_EN
  ,
  input  logic                   acc_clr,
  output logic [4*W-1:0]         acc_y
`endif
);

  mult_issue_state_t state_r;
  mult_issue_state_t state_nxt_s;

  logic [2*W-1:0] head_s;
  logic           full_s;
  logic           empty_s;
  logic           push_s;
  logic           pop_s;
  logic           capture_s;
  logic           result_free_s;

  logic           mult_start_r;
  logic [W-1:0]   mult_a_r;
  logic [W-1:0]   mult_b_r;
  logic           res_valid_r;
  logic [2*W-1:0] res_y_r;

  assign op_ready = !full_s;
  assign push_s   = op_valid && !full_s;

  op_fifo #(
    .DEPTH (DEPTH),
    .DW    (2*W)
  ) u_op_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .din   ({op_a, op_b}),
    .dout  (head_s),
    .full  (full_s),
    .empty (empty_s),
    .count (fifo_cnt)
  );

  // A new issue may only start once the previous result has been handed off,
  // which keeps at most one product in flight or held.
  assign result_free_s = !res_valid_r || res_ready;

  // Next-state, FIFO pop and product capture decisions.
  always_comb begin
    state_nxt_s = state_r;
    pop_s       = 1'b0;
    capture_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (!empty_s && result_free_s) begin
          pop_s       = 1'b1;
          state_nxt_s = START;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      START: begin
        if (mult_busy) begin
          state_nxt_s = WAIT_DONE;
        end else begin
          state_nxt_s = START;
        end
      end
      WAIT_DONE: begin
        if (!mult_busy) begin
          capture_s   = 1'b1;
          state_nxt_s = HOLD;
        end else begin
          state_nxt_s = WAIT_DONE;
        end
      end
      HOLD: begin
        if (res_ready) begin
          if (!empty_s) begin
            pop_s       = 1'b1;
            state_nxt_s = START;
          end else begin
            state_nxt_s = IDLE;
          end
        end else begin
          state_nxt_s = HOLD;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Operand, start and result registers; operands only change on a pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mult_start_r <= 1'b0;
      mult_a_r     <= {W{1'b0}};
      mult_b_r     <= {W{1'b0}};
      res_valid_r  <= 1'b0;
      res_y_r      <= {(2*W){1'b0}};
    end else begin
      mult_start_r <= (state_nxt_s == START);
      if (pop_s) begin
        mult_a_r <= head_s[2*W-1:W];
        mult_b_r <= head_s[W-1:0];
      end
      if (capture_s) begin
        res_y_r     <= mult_y;
        res_valid_r <= 1'b1;
      end else if (res_valid_r && res_ready) begin
        res_valid_r <= 1'b0;
      end
    end
  end

  assign mult_start = mult_start_r;
  assign mult_a     = mult_a_r;
  assign mult_b     = mult_b_r;
  assign res_valid  = res_valid_r;
  assign res_y      = res_y_r;

`ifdef MULT_ISSUE_ACC_EN
  logic [4*W-1:0] acc_r;

  // Running sum of products; a clear coinciding with a capture loads the
  // product alone.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_r <= {(4*W){1'b0}};
    end else if (capture_s) begin
      acc_r <= (acc_clr ? {(4*W){1'b0}} : acc_r) + {{(2*W){1'b0}}, mult_y};
    end else if (acc_clr) begin
      acc_r <= {(4*W){1'b0}};
    end
  end

  assign acc_y = acc_r;
`endif

endmodule

// File: tb/tb_mult_issue.sv
`timescale 1ns/1ps
module tb_mult_issue;

  localparam int W     = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          op_valid = 1'b0;
  logic          op_ready;
  logic [W-1:0]  op_a = 8'd0;
  logic [W-1:0]  op_b = 8'd0;
  logic          mult_start;
  logic [W-1:0]  mult_a;
  logic [W-1:0]  mult_b;
  logic          mult_busy = 1'b0;
  logic [15:0]   mult_y = 16'd0;
  logic          res_valid;
  logic          res_ready = 1'b1;
  logic [15:0]   res_y;
  logic [CW-1:0] fifo_cnt;
`ifdef MULT_ISSUE_ACC_EN
  logic          acc_clr = 1'b0;
  logic [31:0]   acc_y;
`endif

  mult_issue #(.DEPTH(DEPTH), .W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .op_a       (op_a),
    .op_b       (op_b),
    .mult_start (mult_start),
    .mult_a     (mult_a),
    .mult_b     (mult_b),
    .mult_busy  (mult_busy),
    .mult_y     (mult_y),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_y      (res_y),
    .fifo_cnt   (fifo_cnt)
`ifdef MULT_ISSUE_ACC_EN
    ,
    .acc_clr    (acc_clr),
    .acc_y      (acc_y)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural multiplier: busy for busy_len cycles after a start,
  // held busy while stall is set. Independent of the DUT reset.
  int   m_cnt    = 0;
  int   busy_len = 8;
  logic stall    = 1'b0;
  always @(posedge clk) begin
    if (!mult_busy && mult_start) begin
      mult_busy <= 1'b1;
      m_cnt     <= busy_len;
      mult_y    <= {8'd0, mult_a} * {8'd0, mult_b};
    end else if (mult_busy) begin
      if (m_cnt > 1) m_cnt <= m_cnt - 1;
      else if (!stall) mult_busy <= 1'b0;
    end
  end

  // Reference model state
  logic [15:0] pair_q[$];     // accepted, not yet issued operand pairs
  logic [15:0] got_q[$];      // results handed downstream
  logic        outstanding = 1'b0;
  logic [15:0] cur_pair = 16'd0;
  logic [15:0] prod_m = 16'd0;
  logic        prev_rv = 1'b0;
  logic        prev_ms = 1'b0;
  logic        hold_prev = 1'b0;
  logic [15:0] held_y = 16'd0;
  int          rv_rises = 0;
  int          ms_rises = 0;
  logic [31:0] acc_m = 32'd0;
  logic        clr_prev = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  // Compare process: checks DUT outputs against the model every cycle.
  always @(negedge clk) begin
    if (!rst) begin
      pair_q.delete();
      outstanding = 1'b0;
      prev_rv     = 1'b0;
      prev_ms     = 1'b0;
      hold_prev   = 1'b0;
      acc_m       = 32'd0;
      clr_prev    = 1'b0;
    end else begin
      if (mult_start && !prev_ms) begin
        ms_rises++;
        chk("single_outstanding", outstanding, 1'b0);
        if (pair_q.size() == 0) begin
          chk("spurious_start", 1'b1, 1'b0);
        end else begin
          cur_pair = pair_q.pop_front();
          chk("issue_operands", {mult_a, mult_b}, cur_pair);
        end
        outstanding = 1'b1;
      end
      chk("fifo_occupancy", fifo_cnt, pair_q.size());
      chk("op_ready_vs_full", op_ready, (int'(fifo_cnt) < DEPTH));
      if (outstanding && !res_valid)
        chk("operand_stable", {mult_a, mult_b}, cur_pair);
      if (res_valid && !prev_rv) begin
        rv_rises++;
        prod_m = {8'd0, cur_pair[15:8]} * {8'd0, cur_pair[7:0]};
        chk("result_had_issue", outstanding, 1'b1);
        chk("result_value", res_y, prod_m);
        outstanding = 1'b0;
        acc_m = (clr_prev ? 32'd0 : acc_m) + {16'd0, prod_m};
      end else if (clr_prev) begin
        acc_m = 32'd0;
      end
`ifdef MULT_ISSUE_ACC_EN
      chk("acc_model", acc_y, acc_m);
      clr_prev = acc_clr;
`endif
      if (res_valid && hold_prev)
        chk("result_stable", res_y, held_y);
      hold_prev = res_valid && !res_ready;
      held_y    = res_y;
      if (res_valid && res_ready) got_q.push_back(res_y);
      if (op_valid && op_ready) pair_q.push_back({op_a, op_b});
      prev_rv = res_valid;
      prev_ms = mult_start;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] b);
    int k = 0;
    op_valid = 1'b1;
    op_a = a;
    op_b = b;
    while (!op_ready && k < 300) begin
      tick();
      k++;
    end
    if (!op_ready) chk("push_timeout", 1'b0, 1'b1);
    tick();
    op_valid = 1'b0;
  endtask

  task automatic wait_results(input int n);
    int k = 0;
    while (got_q.size() < n && k < 600) begin
      tick();
      k++;
    end
    if (got_q.size() < n) chk("result_timeout", got_q.size(), n);
    repeat (3) tick();
  endtask

  task automatic wait_wait_done();
    int k = 0;
    while (!(mult_busy && !mult_start) && k < 300) begin
      tick();
      k++;
    end
    if (!(mult_busy && !mult_start)) chk("busy_timeout", 1'b0, 1'b1);
  endtask

  int rv0;
  int ms0;
  int kk;

  initial begin
    repeat (3) tick();
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_mult_start", mult_start, 1'b0);
    rst = 1'b1;
    tick();
    chk("rst_op_ready", op_ready, 1'b1);
    chk("rst_fifo_cnt", fifo_cnt, 0);
    chk("rst_res_y", res_y, 0);
    chk("rst_mult_a", mult_a, 0);
    chk("rst_mult_b", mult_b, 0);
`ifdef MULT_ISSUE_ACC_EN
    chk("rst_acc_y", acc_y, 0);
`endif

    // Three products in order, one pulse each
    got_q.delete();
    rv0 = rv_rises;
    push(8'd3, 8'd4);
    push(8'd5, 8'd12);
    push(8'd8, 8'd7);
    wait_results(3);
    chk("seq_res0", got_q[0], 12);
    chk("seq_res1", got_q[1], 60);
    chk("seq_res2", got_q[2], 56);
    chk("seq_pulses", rv_rises - rv0, 3);

`ifdef MULT_ISSUE_ACC_EN
    chk("acc_sum", acc_y, 128);
    acc_clr = 1'b1;
    tick();
    acc_clr = 1'b0;
    tick();
    chk("acc_cleared", acc_y, 0);
    got_q.delete();
    push(8'd1, 8'd1);
    wait_results(1);
    chk("acc_after_clr", acc_y, 1);
    // clear held across the capture edge: loads the product alone
    acc_clr = 1'b1;
    push(8'd3, 8'd3);
    kk = 0;
    while (!res_valid && kk < 300) begin
      tick();
      kk++;
    end
    acc_clr = 1'b0;
    chk("acc_clr_capture", acc_y, 9);
    repeat (3) tick();
`endif

    // Extremes
    got_q.delete();
    push(8'd255, 8'd255);
    push(8'd0, 8'd200);
    wait_results(2);
    chk("max_product", got_q[0], 65025);
    chk("zero_product", got_q[1], 0);

    // Result held with res_ready low blocks further issue
    got_q.delete();
    res_ready = 1'b0;
    push(8'd2, 8'd2);
    kk = 0;
    while (!res_valid && kk < 300) begin
      tick();
      kk++;
    end
    push(8'd6, 8'd6);
    ms0 = ms_rises;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("hold_valid", res_valid, 1'b1);
      chk("hold_y", res_y, 4);
    end
    chk("hold_no_start", ms_rises - ms0, 0);
    chk("hold_queued", fifo_cnt, 1);
    res_ready = 1'b1;
    wait_results(2);
    chk("hold_res0", got_q[0], 4);
    chk("hold_res1", got_q[1], 36);

    // FIFO full while multiplier stalled
    got_q.delete();
    stall = 1'b1;
    push(8'd1, 8'd1);
    wait_wait_done();
    push(8'd2, 8'd1);
    push(8'd3, 8'd1);
    push(8'd4, 8'd1);
    push(8'd5, 8'd1);
    chk("full_cnt", fifo_cnt, 4);
    chk("full_not_ready", op_ready, 1'b0);
    op_valid = 1'b1;
    op_a = 8'd6;
    op_b = 8'd1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("full_refuse_ready", op_ready, 1'b0);
      chk("full_refuse_cnt", fifo_cnt, 4);
    end
    stall = 1'b0;
    kk = 0;
    while (!op_ready && kk < 300) begin
      tick();
      kk++;
    end
    tick();
    op_valid = 1'b0;
    chk("fifth_accepted_cnt", fifo_cnt, 4);
    wait_results(6);
    for (int i = 0; i < 6; i++) chk("full_seq_res", got_q[i], i + 1);

    // Reset during WAIT_DONE with two pairs queued
    got_q.delete();
    push(8'd9, 8'd9);
    push(8'd2, 8'd3);
    push(8'd4, 8'd5);
    wait_wait_done();
    chk("pre_reset_cnt", fifo_cnt, 2);
    rv0 = rv_rises;
    ms0 = ms_rises;
    rst = 1'b0;
    #1;
    chk("async_rst_start", mult_start, 1'b0);
    chk("async_rst_valid", res_valid, 1'b0);
    chk("async_rst_cnt", fifo_cnt, 0);
    tick();
    tick();
    rst = 1'b1;
    repeat (40) tick();
    chk("post_reset_no_result", rv_rises - rv0, 0);
    chk("post_reset_no_start", ms_rises - ms0, 0);
    chk("post_reset_ready", op_ready, 1'b1);
    chk("post_reset_got", got_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_issue.md
MULT_ISSUE -- requirements
Module: mult_issue

Interface
REQ-001 Parameter DEPTH, default 4, operand FIFO entries (power of two, >=2).
REQ-002 Parameter W, default 8, operand width; product width is 2*W.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 op_valid  input  1  upstream operand pair valid.
REQ-006 op_ready  output  1  block can accept an operand pair.
REQ-007 op_a, op_b  input  W each  operands.
REQ-008 mult_start  output  1  start request to multiplier.
REQ-009 mult_a, mult_b  output  W each  operands presented to multiplier.
REQ-010 mult_busy  input  1  multiplier busy flag.
REQ-011 mult_y  input  2*W  multiplier product.
REQ-012 res_valid  output  1  result available.
REQ-013 res_ready  input  1  downstream accepts result.
REQ-014 res_y  output  2*W  captured product.
REQ-015 fifo_cnt  output  $clog2(DEPTH)+1  operand FIFO occupancy.

Function
REQ-016 Operand pair SHALL be pushed when op_valid && op_ready; op_ready = !full, so a push is never accepted when full, even if a pop occurs in the same cycle.
REQ-017 FSM SHALL have states IDLE, START, WAIT_DONE, HOLD.
REQ-018 IDLE: if FIFO non-empty and no unaccepted result is held (res_valid==0, or res_valid && res_ready this cycle), pop head into mult_a/mult_b registers, go START; otherwise stay in IDLE.
REQ-019 START: mult_start SHALL be 1; stay until mult_busy==1 is sampled, then go WAIT_DONE with mult_start 0 from the next cycle.
REQ-020 WAIT_DONE: mult_start 0; when mult_busy==0 is sampled, capture mult_y into res_y, set res_valid, go HOLD.
REQ-021 HOLD: res_valid SHALL stay 1 and res_y stable until res_ready==1; on that cycle clear res_valid and go IDLE, or issue directly per REQ-018 if the FIFO is non-empty.
REQ-022 mult_a/mult_b SHALL remain stable from the pop cycle until WAIT_DONE exits.
REQ-023 Simultaneous push and pop SHALL leave fifo_cnt unchanged; pointers SHALL wrap modulo DEPTH.
REQ-024 Minimum issue-to-result latency SHALL be 2 cycles plus the multiplier busy duration; at most one multiplication SHALL be outstanding.

Reset
REQ-025 On rst==0, asynchronously: FSM=IDLE, FIFO empty, fifo_cnt=0, op_ready=1 after release, mult_start=0, mult_a=mult_b=0, res_valid=0, res_y=0, accumulator=0.
REQ-026 Reset mid-operation SHALL discard queued operands and any in-flight result; no result for a discarded operation SHALL appear after release.

Configuration
REQ-027 With MULT_ISSUE_ACC_EN defined: output acc_y (4*W bits) and input acc_clr SHALL exist; every captured product SHALL be added to acc_y in the capture cycle; acc_clr==1 zeros acc_y, and when it coincides with a capture acc_y SHALL load that product alone; wrap modulo 2^(4*W).
REQ-028 Without MULT_ISSUE_ACC_EN: acc_y, acc_clr and the adder SHALL be absent; all other behaviour is identical.

Structure
REQ-029 Package mult_pkg SHALL hold the FSM state enum (mult_issue_state_t) and default constants MULT_W=8, MULT_ISSUE_DEPTH=4.
REQ-030 Operand storage SHALL be a sub-module op_fifo (synchronous FIFO, DEPTH x 2*W, push/pop/full/empty/count); the FSM, result register and accumulator stay in mult_issue.

Verification
REQ-031 Push (3,4),(5,12),(8,7) with behavioural multiplier (busy 8 cycles), res_ready=1 -> res_y 12, 60, 56 in order, one res_valid pulse each.
REQ-032 Push (255,255) -> res_y=65025; (0,200) -> res_y=0.
REQ-033 Push 5 pairs back-to-back with multiplier stalled -> op_ready=0 after 4 accepted (fifo_cnt=4 while the first is being issued), 5th accepted only after a pop.
REQ-034 Hold res_ready=0 for 20 cycles after (2,2) -> res_valid=1, res_y=4 stable, no new mult_start until res_ready=1.
REQ-035 Assert rst=0 during WAIT_DONE with 2 pairs queued -> mult_start=0, res_valid=0, fifo_cnt=0 immediately; no result after release.
REQ-036 With MULT_ISSUE_ACC_EN: (3,4),(5,12),(8,7) -> acc_y=128; acc_clr then (1,1) -> acc_y=1.
